// File: rtl/ima_adpcm_pkg.sv
// Shared constants for the IMA ADPCM packer: header layout, FSM encodings, FIFO entry format.
package ima_adpcm_pkg;

    localparam int         HDR_BYTES    = 4;
    localparam logic [7:0] HDR_RESERVED = 8'h00;

    // Header states are contiguous so the header window is a simple range check.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR0 = 3'd1;
    localparam logic [2:0] ST_HDR1 = 3'd2;
    localparam logic [2:0] ST_HDR2 = 3'd3;
    localparam logic [2:0] ST_HDR3 = ST_HDR0 + 3'(HDR_BYTES - 1);
    localparam logic [2:0] ST_DLO  = 3'd5;
    localparam logic [2:0] ST_DHI  = 3'd6;

    typedef struct packed {
        logic       last;
        logic [7:0] dat;
    } fifo_ent_t;

endpackage

// File: rtl/adpcm_byte_fifo.sv
// Byte FIFO with first-word fall-through. Latency: write visible on rd_vld one cycle later.
// Backpressure: wr_rdy low only when full with no read this cycle; refused writes are discarded.
module adpcm_byte_fifo
    import ima_adpcm_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_vld,
    input  fifo_ent_t                wr_dat,
    output logic                     wr_rdy,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output fifo_ent_t                rd_dat,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_LVL = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    fifo_ent_t     mem_q [DEPTH];
    logic          rd_fire, wr_fire;

    always_comb begin
        rd_vld   = (level_q != '0);
        rd_fire  = rd_vld && rd_rdy;
        wr_rdy   = (level_q != FULL_LVL) || rd_fire;
        wr_fire  = wr_vld && wr_rdy;
        wr_ptr_d = wr_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (wr_fire && !rd_fire) begin
            level_d = level_q + 1'b1;
        end else if (rd_fire && !wr_fire) begin
            level_d = level_q - 1'b1;
        end
        // Masked so the byte lanes read as zero whenever nothing is held.
        rd_dat = rd_vld ? mem_q[rd_ptr_q] : '0;
        level  = level_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_dat;
        end
    end

endmodule

// File: rtl/ima_adpcm_packer.sv
// Frames ADPCM nibbles into header + packed data bytes. Latency: byte on outValid 1 cycle after write.
// Backpressure: outReady stalls the FIFO; upstream throttles on almostFull, full FIFO drops bytes (overflow).
module ima_adpcm_packer
    import ima_adpcm_pkg::*;
#(
    parameter int NIBBLES_PER_BLOCK = 8,
    parameter int FIFO_DEPTH        = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [3:0]                    inPCM,
    input  logic                          inValid,
    input  logic [15:0]                   inPredictSamp,
    input  logic [6:0]                    inStepIndex,
    output logic [7:0]                    outByte,
    output logic                          outLast,
    output logic                          outValid,
    input  logic                          outReady,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
    output logic                          almostFull,
    output logic                          overflow,
    output logic                          protoErr
);

    localparam int                  LW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0]       AF_LVL   = LW'(FIFO_DEPTH - 5);
    localparam logic [7:0]          LAST_CNT = 8'(NIBBLES_PER_BLOCK);

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  pend_q, pend_d;
    logic [15:0] last_pred_q, last_pred_d;
    logic [6:0]  last_idx_q, last_idx_d;
    logic [15:0] hdr_pred_q, hdr_pred_d;
    logic [6:0]  hdr_idx_q, hdr_idx_d;
    logic        overflow_q, overflow_d;
    logic        proto_err_q, proto_err_d;

    logic        accept;
    logic        hdr_busy;
    logic        wr_vld, wr_rdy;
    fifo_ent_t   wr_dat, rd_dat;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        last_pred_d = last_pred_q;
        last_idx_d  = last_idx_q;
        hdr_pred_d  = hdr_pred_q;
        hdr_idx_d   = hdr_idx_q;
        overflow_d  = overflow_q;
        proto_err_d = proto_err_q;
        accept      = 1'b0;
        wr_vld      = 1'b0;
        wr_dat      = '0;
        hdr_busy    = (state_q >= ST_HDR0) && (state_q <= ST_HDR3);

        case (state_q)
            ST_IDLE: begin
                if (inValid) begin
                    // Header carries the predictor state from before this block's first code.
                    hdr_pred_d = last_pred_q;
                    hdr_idx_d  = last_idx_q;
                    pend_d     = inPCM;
                    cnt_d      = 8'd1;
                    state_d    = ST_HDR0;
                    accept     = 1'b1;
                end
            end
            ST_HDR0: begin
                wr_vld  = 1'b1;
                wr_dat  = '{last: 1'b0, dat: hdr_pred_q[7:0]};
                state_d = ST_HDR1;
            end
            ST_HDR1: begin
                wr_vld  = 1'b1;
                wr_dat  = '{last: 1'b0, dat: hdr_pred_q[15:8]};
                state_d = ST_HDR2;
            end
            ST_HDR2: begin
                wr_vld  = 1'b1;
                wr_dat  = '{last: 1'b0, dat: {1'b0, hdr_idx_q}};
                state_d = ST_HDR3;
            end
            ST_HDR3: begin
                wr_vld  = 1'b1;
                wr_dat  = '{last: 1'b0, dat: HDR_RESERVED};
                state_d = ST_DHI;
            end
            ST_DLO: begin
                if (inValid) begin
                    pend_d  = inPCM;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = ST_DHI;
                    accept  = 1'b1;
                end
            end
            ST_DHI: begin
                if (inValid) begin
                    wr_vld = 1'b1;
                    accept = 1'b1;
                    if (cnt_q + 8'd1 == LAST_CNT) begin
                        wr_dat  = '{last: 1'b1, dat: {inPCM, pend_q}};
                        cnt_d   = 8'd0;
                        state_d = ST_IDLE;
                    end else begin
                        wr_dat  = '{last: 1'b0, dat: {inPCM, pend_q}};
                        cnt_d   = cnt_q + 8'd1;
                        state_d = ST_DLO;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            last_pred_d = inPredictSamp;
            last_idx_d  = inStepIndex;
        end
        if (inValid && hdr_busy) begin
            proto_err_d = 1'b1;
        end
        if (wr_vld && !wr_rdy) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_q      <= '0;
            last_pred_q <= '0;
            last_idx_q  <= '0;
            hdr_pred_q  <= '0;
            hdr_idx_q   <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            last_pred_q <= last_pred_d;
            last_idx_q  <= last_idx_d;
            hdr_pred_q  <= hdr_pred_d;
            hdr_idx_q   <= hdr_idx_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
        end
    end

    adpcm_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .wr_vld (wr_vld),
        .wr_dat (wr_dat),
        .wr_rdy (wr_rdy),
        .rd_vld (outValid),
        .rd_rdy (outReady),
        .rd_dat (rd_dat),
        .level  (fifoLevel)
    );

    always_comb begin
        outByte    = rd_dat.dat;
        outLast    = rd_dat.last;
        almostFull = (fifoLevel >= AF_LVL);
        overflow   = overflow_q;
        protoErr   = proto_err_q;
    end

endmodule

// File: tb/tb_ima_adpcm_packer.sv
// Bench for ima_adpcm_packer: directed framing scenarios plus randomized traffic
// scored against a byte-list reference model of the block format.
module tb_ima_adpcm_packer;

    localparam int N     = 8;
    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  inPCM = '0;
    logic        inValid = 1'b0;
    logic [15:0] inPredictSamp = '0;
    logic [6:0]  inStepIndex = '0;
    logic [7:0]  outByte;
    logic        outLast;
    logic        outValid;
    logic        outReady = 1'b1;
    logic [4:0]  fifoLevel;
    logic        almostFull;
    logic        overflow;
    logic        protoErr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: predictor history, position in block, expected byte stream.
    logic [15:0] m_pred;
    logic [6:0]  m_idx;
    logic [3:0]  m_pend;
    int          m_cnt;
    int          m_hdr_left;
    bit          m_perr;
    logic [8:0]  exp_q[$];
    logic [8:0]  got_q[$];
    bit          sb_en = 1'b1;
    int          rdy_mode = 0;
    bit          p_stall = 1'b0;
    logic [8:0]  p_out = '0;
    logic [8:0]  exp37[8] = '{9'h000, 9'h000, 9'h000, 9'h000, 9'h021, 9'h043, 9'h065, 9'h187};

    always #5 clock = ~clock;

    ima_adpcm_packer #(
        .NIBBLES_PER_BLOCK (N),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .inPCM         (inPCM),
        .inValid       (inValid),
        .inPredictSamp (inPredictSamp),
        .inStepIndex   (inStepIndex),
        .outByte       (outByte),
        .outLast       (outLast),
        .outValid      (outValid),
        .outReady      (outReady),
        .fifoLevel     (fifoLevel),
        .almostFull    (almostFull),
        .overflow      (overflow),
        .protoErr      (protoErr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor at the falling edge: what is seen here is what the DUT sees at the next rising edge.
    always @(negedge clock) begin
        logic       busy;
        logic [8:0] e;
        if (p_stall) check("hold_stable", 32'({outLast, outByte}), 32'(p_out));
        p_stall = !reset && outValid && !outReady;
        p_out   = {outLast, outByte};
        if (reset) begin
            m_pred = '0; m_idx = '0; m_pend = '0;
            m_cnt = 0; m_hdr_left = 0; m_perr = 1'b0;
            exp_q.delete();
        end else begin
            if (outValid && outReady) begin
                got_q.push_back({outLast, outByte});
                if (sb_en) begin
                    check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sb_byte", 32'({outLast, outByte}), 32'(e));
                    end
                end
            end
            busy = (m_hdr_left > 0);
            if (busy) m_hdr_left--;
            if (inValid) begin
                if (busy) begin
                    m_perr = 1'b1;
                end else begin
                    if (m_cnt == 0) begin
                        exp_q.push_back({1'b0, m_pred[7:0]});
                        exp_q.push_back({1'b0, m_pred[15:8]});
                        exp_q.push_back({2'b00, m_idx});
                        exp_q.push_back(9'h000);
                        m_pend = inPCM;
                        m_cnt = 1;
                        m_hdr_left = 4;
                    end else if (m_cnt % 2 == 1) begin
                        m_cnt++;
                        exp_q.push_back({m_cnt == N, inPCM, m_pend});
                        if (m_cnt == N) m_cnt = 0;
                    end else begin
                        m_pend = inPCM;
                        m_cnt++;
                    end
                    m_pred = inPredictSamp;
                    m_idx  = inStepIndex;
                end
            end
        end
    end

    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0:       outReady = 1'b1;
            1:       outReady = 1'b0;
            2:       outReady = !outReady;
            default: outReady = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [3:0] code, input logic [15:0] pred, input logic [6:0] idx);
        inValid = 1'b1;
        inPCM = code;
        inPredictSamp = pred;
        inStepIndex = idx;
        step();
        inValid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic send_block(input int gap, input logic [15:0] lp, input logic [6:0] li);
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) send(4'($urandom), lp, li);
            else            send(4'($urandom), 16'($urandom), 7'($urandom));
            idle((i == 0 && gap < 4) ? 4 : gap);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || outValid) && t < 400) begin
            step();
            t++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        idle(2);
        reset = 1'b0;
        check("rst_outValid", 32'(outValid), 32'd0);
        check("rst_outLast", 32'(outLast), 32'd0);
        check("rst_outByte", 32'(outByte), 32'd0);
        check("rst_fifoLevel", 32'(fifoLevel), 32'd0);
        check("rst_almostFull", 32'(almostFull), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_protoErr", 32'(protoErr), 32'd0);

        // Codes 1..8 after reset.
        got_q.delete();
        send(4'd1, 16'($urandom), 7'($urandom));
        idle(4);
        for (int c = 2; c <= 8; c++) send(4'(c), 16'($urandom), 7'($urandom));
        drain();
        check("blk1_count", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) check("blk1_byte", 32'(got_q[i]), 32'(exp37[i]));

        // Header of the next block carries the state left by the previous block's last code.
        got_q.delete();
        send_block(1, 16'h1234, 7'd42);
        send_block(0, 16'($urandom), 7'($urandom));
        drain();
        check("hdr_count", 32'(got_q.size()), 32'd16);
        if (got_q.size() >= 12) begin
            check("hdr_b0", 32'(got_q[8]), 32'h034);
            check("hdr_b1", 32'(got_q[9]), 32'h012);
            check("hdr_b2", 32'(got_q[10]), 32'h02A);
            check("hdr_b3", 32'(got_q[11]), 32'h000);
        end

        // Stalled output, three blocks: FIFO saturates and later bytes are dropped.
        rdy_mode = 1;
        step();
        sb_en = 1'b0;
        got_q.delete();
        for (int b = 0; b < 3; b++) send_block(5, 16'($urandom), 7'($urandom));
        idle(4);
        check("ovf_level", 32'(fifoLevel), 32'(DEPTH));
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_almostFull", 32'(almostFull), 32'd1);
        check("ovf_model_size", 32'(exp_q.size()), 32'(3 * (4 + N / 2)));
        rdy_mode = 0;
        for (int t = 0; t < 60 && (outValid || got_q.size() < DEPTH); t++) step();
        check("ovf_released", 32'(got_q.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH && i < got_q.size() && i < exp_q.size(); i++)
            check("ovf_byte", 32'(got_q[i]), 32'(exp_q[i]));
        do_reset();
        sb_en = 1'b1;
        check("ovf_cleared", 32'(overflow), 32'd0);
        check("ovf_rst_byte", 32'(outByte), 32'd0);

        // Ready toggling every cycle.
        rdy_mode = 2;
        got_q.delete();
        send_block(0, 16'($urandom), 7'($urandom));
        drain();
        check("toggle_count", 32'(got_q.size()), 32'd8);

        // Reset in the middle of a block.
        rdy_mode = 1;
        step();
        send(4'($urandom), 16'($urandom), 7'($urandom));
        idle(4);
        send(4'($urandom), 16'($urandom), 7'($urandom));
        send(4'($urandom), 16'($urandom), 7'($urandom));
        check("mid_pre_level", 32'(fifoLevel), 32'(exp_q.size()));
        do_reset();
        check("mid_outValid", 32'(outValid), 32'd0);
        check("mid_level", 32'(fifoLevel), 32'd0);
        rdy_mode = 0;
        got_q.delete();
        send_block(1, 16'($urandom), 7'($urandom));
        drain();
        check("mid_count", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("mid_hdr", 32'(got_q[i]), 32'h000);

        // Code arriving while the header is being written.
        got_q.delete();
        send(4'($urandom), 16'($urandom), 7'($urandom));
        idle(1);
        send(4'($urandom), 16'hBEEF, 7'h55);
        idle(2);
        for (int i = 1; i < N; i++) send(4'($urandom), 16'($urandom), 7'($urandom));
        check("perr_flag", 32'(protoErr), 32'(m_perr));
        check("perr_set", 32'(protoErr), 32'd1);
        send_block(2, 16'($urandom), 7'($urandom));
        drain();
        check("perr_count", 32'(got_q.size()), 32'd16);

        // Randomized traffic with random readiness, throttled on almostFull.
        do_reset();
        rdy_mode = 3;
        for (int k = 0; k < 500; k++) begin
            idle($urandom_range(0, 5));
            if (!almostFull) send(4'($urandom), 16'($urandom), 7'($urandom));
        end
        rdy_mode = 0;
        drain();
        check("rnd_overflow", 32'(overflow), 32'd0);
        check("rnd_protoErr", 32'(protoErr), 32'(m_perr));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
